// File: rtl/wdt_rst_ctrl_if.sv
// Signal bundle between the watchdog overflow source, software and the
// watchdog reset controller.
interface wdt_rst_ctrl_if;
  // Handshake: wdov_i is a level flag that stays high until the controller
  // returns wdovclr_o, a single-cycle pulse one cycle after the accepted rise.
  // Rises that the controller does not accept (disabled, RESET, HOLDOFF) get
  // no clear pulse. irq_ack and cause_clr are single-cycle pulses from software.
  logic       en;
  logic       wdov_i;
  logic       wdovclr_o;
  logic       irq_ack;
  logic       irq_o;
  logic [3:0] strikes_o;
  logic       sys_rst_no;
  logic       rst_cause_o;
  logic       cause_clr;
  logic [1:0] fsm_state;

  modport master (
    output en, wdov_i, irq_ack, cause_clr,
    input  wdovclr_o, irq_o, strikes_o, sys_rst_no, rst_cause_o, fsm_state
  );

  modport slave (
    input  en, wdov_i, irq_ack, cause_clr,
    output wdovclr_o, irq_o, strikes_o, sys_rst_no, rst_cause_o, fsm_state
  );
endinterface

// File: rtl/wdt_rst_ctrl.sv
// Watchdog overflow consumer: counts overflow strikes, raises a warning
// interrupt and escalates to a timed active-low system reset plus hold-off.
module wdt_rst_ctrl #(
  parameter int unsigned STRIKES     = 2,
  parameter int unsigned RST_CYCLES  = 16,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input logic          clk,
  input logic          rst_n,
  wdt_rst_ctrl_if.slave bus
);

  localparam int unsigned CNT_MAX = (RST_CYCLES > HOLD_CYCLES) ? RST_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WARN    = 2'd1;
  localparam logic [1:0] RESET   = 2'd2;
  localparam logic [1:0] HOLDOFF = 2'd3;

  localparam logic [3:0]       STRIKES_L = 4'(STRIKES);
  localparam logic [3:0]       STRIKE_1  = 4'd1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [1:0]       state, state_d;
  logic [3:0]       strikes, strikes_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             irq, irq_d;
  logic             sys_rst_n, sys_rst_n_d;
  logic             cause, cause_d;
  logic             clr, wdov_q;
  logic             ov_evt, evt_ok;
  logic [3:0]       strikes_inc;

  assign ov_evt = bus.wdov_i & ~wdov_q;
  assign evt_ok = ov_evt & bus.en & ((state == IDLE) | (state == WARN));
  // An ack landing with a new event restarts the count at one strike.
  assign strikes_inc = (bus.irq_ack ? 4'd0 : strikes) + STRIKE_1;

  always_comb begin
    state_d     = state;
    strikes_d   = strikes;
    cnt_d       = cnt;
    irq_d       = irq;
    sys_rst_n_d = sys_rst_n;
    cause_d     = bus.cause_clr ? 1'b0 : cause;
    case (state)
      IDLE: begin
        if (evt_ok) begin
          strikes_d = STRIKE_1;
          irq_d     = 1'b1;
          state_d   = WARN;
          if (STRIKE_1 == STRIKES_L) begin
            state_d = RESET;
            cnt_d   = RST_LOAD;
            cause_d = 1'b1;
          end
        end
      end
      WARN: begin
        if (!bus.en) begin
          state_d   = IDLE;
          strikes_d = 4'd0;
          irq_d     = 1'b0;
        end else if (evt_ok) begin
          strikes_d = strikes_inc;
          irq_d     = 1'b1;
          if (strikes_inc == STRIKES_L) begin
            state_d = RESET;
            cnt_d   = RST_LOAD;
            cause_d = 1'b1;
          end
        end else if (bus.irq_ack) begin
          state_d   = IDLE;
          strikes_d = 4'd0;
          irq_d     = 1'b0;
        end
      end
      RESET: begin
        // The entry cycle keeps sys_rst_n high; the pulse covers the next RST_CYCLES.
        if (cnt != CNT_ZERO) begin
          cnt_d       = cnt - CNT_ONE;
          sys_rst_n_d = 1'b0;
        end else begin
          sys_rst_n_d = 1'b1;
          state_d     = HOLDOFF;
          cnt_d       = HOLD_LOAD;
          strikes_d   = 4'd0;
          irq_d       = 1'b0;
        end
      end
      default: begin
        if (cnt == CNT_ZERO) state_d = IDLE;
        else                 cnt_d   = cnt - CNT_ONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      strikes   <= 4'd0;
      cnt       <= CNT_ZERO;
      irq       <= 1'b0;
      sys_rst_n <= 1'b1;
      cause     <= 1'b0;
      clr       <= 1'b0;
      wdov_q    <= 1'b0;
    end else begin
      state     <= state_d;
      strikes   <= strikes_d;
      cnt       <= cnt_d;
      irq       <= irq_d;
      sys_rst_n <= sys_rst_n_d;
      cause     <= cause_d;
      clr       <= evt_ok;
      wdov_q    <= bus.wdov_i;
    end
  end

  assign bus.wdovclr_o   = clr;
  assign bus.irq_o       = irq;
  assign bus.strikes_o   = strikes;
  assign bus.sys_rst_no  = sys_rst_n;
  assign bus.rst_cause_o = cause;
  assign bus.fsm_state   = state;

endmodule

// File: tb/tb_wdt_rst_ctrl.sv
// Directed bench for wdt_rst_ctrl with STRIKES=2, RST_CYCLES=16, HOLD_CYCLES=8.
module tb_wdt_rst_ctrl;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WARN    = 2'd1;
  localparam logic [1:0] S_RESET   = 2'd2;
  localparam logic [1:0] S_HOLDOFF = 2'd3;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   fails;

  wdt_rst_ctrl_if bus ();

  wdt_rst_ctrl #(.STRIKES(2), .RST_CYCLES(16), .HOLD_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.en        = 1'b1;
    bus.wdov_i    = 1'b0;
    bus.irq_ack   = 1'b0;
    bus.cause_clr = 1'b0;
  endtask

  // Raise the flag for one cycle; on return the accepting edge has passed.
  task automatic rise_wdov();
    bus.wdov_i = 1'b1;
    tick();
    bus.wdov_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #23;
    tests_run++;
    if (bus.sys_rst_no !== 1'b1) begin fails++; $display("FAIL reset_sys_rst: got %b want 1", bus.sys_rst_no); end
    tests_run++;
    if (bus.irq_o !== 1'b0 || bus.strikes_o !== 4'd0) begin fails++; $display("FAIL reset_irq_strikes: got irq=%b strikes=%0d want 0/0", bus.irq_o, bus.strikes_o); end
    tests_run++;
    if (bus.rst_cause_o !== 1'b0 || bus.wdovclr_o !== 1'b0 || bus.fsm_state !== S_IDLE) begin
      fails++; $display("FAIL reset_misc: got cause=%b clr=%b state=%0d want 0/0/0", bus.rst_cause_o, bus.wdovclr_o, bus.fsm_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  // One rise held three cycles: one clear pulse, one strike.
  task automatic test_event_warn();
    bus.wdov_i = 1'b1;
    tick();
    tests_run++;
    if (bus.wdovclr_o !== 1'b1 || bus.irq_o !== 1'b1 || bus.strikes_o !== 4'd1) begin
      fails++; $display("FAIL first_event: got clr=%b irq=%b strikes=%0d want 1/1/1", bus.wdovclr_o, bus.irq_o, bus.strikes_o);
    end
    tick();
    tests_run++;
    if (bus.wdovclr_o !== 1'b0 || bus.strikes_o !== 4'd1) begin
      fails++; $display("FAIL held_flag_once: got clr=%b strikes=%0d want 0/1", bus.wdovclr_o, bus.strikes_o);
    end
    tick();
    bus.wdov_i = 1'b0;
    tick();
    tests_run++;
    if (bus.wdovclr_o !== 1'b0 || bus.strikes_o !== 4'd1 || bus.fsm_state !== S_WARN) begin
      fails++; $display("FAIL held_flag_end: got clr=%b strikes=%0d state=%0d want 0/1/1", bus.wdovclr_o, bus.strikes_o, bus.fsm_state);
    end
  endtask

  task automatic test_ack();
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    tests_run++;
    if (bus.irq_o !== 1'b0 || bus.strikes_o !== 4'd0 || bus.fsm_state !== S_IDLE) begin
      fails++; $display("FAIL ack_clears: got irq=%b strikes=%0d state=%0d want 0/0/0", bus.irq_o, bus.strikes_o, bus.fsm_state);
    end
    repeat (5) tick();
    rise_wdov();
    tests_run++;
    if (bus.strikes_o !== 4'd1 || bus.sys_rst_no !== 1'b1 || bus.fsm_state !== S_WARN) begin
      fails++; $display("FAIL event_after_ack: got strikes=%0d sys=%b state=%0d want 1/1/1", bus.strikes_o, bus.sys_rst_no, bus.fsm_state);
    end
    tick();
  endtask

  // Entered in WARN with one strike.
  task automatic test_ack_and_event();
    int clr_cnt;
    int low_cnt;
    clr_cnt = 0;
    low_cnt = 0;
    bus.irq_ack = 1'b1;
    bus.wdov_i  = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    bus.wdov_i  = 1'b0;
    tests_run++;
    if (bus.strikes_o !== 4'd1 || bus.irq_o !== 1'b1 || bus.fsm_state !== S_WARN) begin
      fails++; $display("FAIL ack_evt_same: got strikes=%0d irq=%b state=%0d want 1/1/1", bus.strikes_o, bus.irq_o, bus.fsm_state);
    end
    for (int i = 0; i < 6; i++) begin
      if (bus.wdovclr_o) clr_cnt++;
      if (!bus.sys_rst_no) low_cnt++;
      tick();
    end
    tests_run++;
    if (clr_cnt != 1 || low_cnt != 0) begin
      fails++; $display("FAIL ack_evt_pulses: got clr=%0d low=%0d want 1/0", clr_cnt, low_cnt);
    end
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    tick();
  endtask

  task automatic test_escalate();
    rise_wdov();
    repeat (10) tick();
    rise_wdov();
    tests_run++;
    if (bus.fsm_state !== S_RESET || bus.rst_cause_o !== 1'b1 || bus.strikes_o !== 4'd2 || bus.irq_o !== 1'b1 || bus.wdovclr_o !== 1'b1 || bus.sys_rst_no !== 1'b1) begin
      fails++; $display("FAIL reset_entry: got state=%0d cause=%b strikes=%0d irq=%b clr=%b sys=%b want 2/1/2/1/1/1",
                        bus.fsm_state, bus.rst_cause_o, bus.strikes_o, bus.irq_o, bus.wdovclr_o, bus.sys_rst_no);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      tests_run++;
      if (bus.sys_rst_no !== 1'b0 || bus.strikes_o !== 4'd2 || bus.irq_o !== 1'b1) begin
        fails++; $display("FAIL reset_low_%0d: got sys=%b strikes=%0d irq=%b want 0/2/1", i, bus.sys_rst_no, bus.strikes_o, bus.irq_o);
      end
    end
    tick();
    tests_run++;
    if (bus.sys_rst_no !== 1'b1 || bus.fsm_state !== S_HOLDOFF || bus.strikes_o !== 4'd0 || bus.irq_o !== 1'b0) begin
      fails++; $display("FAIL holdoff_entry: got sys=%b state=%0d strikes=%0d irq=%b want 1/3/0/0", bus.sys_rst_no, bus.fsm_state, bus.strikes_o, bus.irq_o);
    end
    for (int i = 1; i < 8; i++) begin
      if (i == 2) bus.wdov_i = 1'b1;
      tick();
      tests_run++;
      if (bus.fsm_state !== S_HOLDOFF || bus.wdovclr_o !== 1'b0 || bus.strikes_o !== 4'd0) begin
        fails++; $display("FAIL holdoff_%0d: got state=%0d clr=%b strikes=%0d want 3/0/0", i, bus.fsm_state, bus.wdovclr_o, bus.strikes_o);
      end
    end
    tick();
    tests_run++;
    if (bus.fsm_state !== S_IDLE || bus.strikes_o !== 4'd0 || bus.rst_cause_o !== 1'b1) begin
      fails++; $display("FAIL holdoff_exit: got state=%0d strikes=%0d cause=%b want 0/0/1", bus.fsm_state, bus.strikes_o, bus.rst_cause_o);
    end
    tick();
    tests_run++;
    if (bus.fsm_state !== S_IDLE || bus.wdovclr_o !== 1'b0) begin
      fails++; $display("FAIL held_flag_after_holdoff: got state=%0d clr=%b want 0/0", bus.fsm_state, bus.wdovclr_o);
    end
    bus.wdov_i    = 1'b0;
    bus.cause_clr = 1'b1;
    tick();
    bus.cause_clr = 1'b0;
    tests_run++;
    if (bus.rst_cause_o !== 1'b0) begin fails++; $display("FAIL cause_clr: got %b want 0", bus.rst_cause_o); end
    tick();
  endtask

  task automatic test_en_drop();
    int low_cnt;
    rise_wdov();
    bus.en = 1'b0;
    tick();
    tests_run++;
    if (bus.fsm_state !== S_IDLE || bus.irq_o !== 1'b0 || bus.strikes_o !== 4'd0) begin
      fails++; $display("FAIL en_drop_warn: got state=%0d irq=%b strikes=%0d want 0/0/0", bus.fsm_state, bus.irq_o, bus.strikes_o);
    end
    rise_wdov();
    tests_run++;
    if (bus.wdovclr_o !== 1'b0 || bus.strikes_o !== 4'd0) begin
      fails++; $display("FAIL disabled_event: got clr=%b strikes=%0d want 0/0", bus.wdovclr_o, bus.strikes_o);
    end
    bus.en = 1'b1;
    tick();
    rise_wdov();
    tick();
    rise_wdov();
    bus.en      = 1'b0;
    bus.irq_ack = 1'b1;
    low_cnt     = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.sys_rst_no) low_cnt++;
      tick();
      bus.irq_ack = 1'b0;
    end
    tests_run++;
    if (low_cnt != 16) begin fails++; $display("FAIL en_drop_reset_len: got %0d low cycles want 16", low_cnt); end
    tests_run++;
    if (bus.fsm_state !== S_IDLE || bus.sys_rst_no !== 1'b1) begin
      fails++; $display("FAIL en_drop_recover: got state=%0d sys=%b want 0/1", bus.fsm_state, bus.sys_rst_no);
    end
    bus.en        = 1'b1;
    bus.cause_clr = 1'b1;
    tick();
    bus.cause_clr = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    rise_wdov();
    tick();
    bus.cause_clr = 1'b1;
    rise_wdov();
    bus.cause_clr = 1'b0;
    tests_run++;
    if (bus.rst_cause_o !== 1'b1 || bus.fsm_state !== S_RESET) begin
      fails++; $display("FAIL cause_set_priority: got cause=%b state=%0d want 1/2", bus.rst_cause_o, bus.fsm_state);
    end
    repeat (5) tick();
    tests_run++;
    if (bus.sys_rst_no !== 1'b0) begin fails++; $display("FAIL fifth_low_cycle: got sys=%b want 0", bus.sys_rst_no); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.sys_rst_no !== 1'b1 || bus.rst_cause_o !== 1'b0) begin
      fails++; $display("FAIL async_reset_out: got sys=%b cause=%b want 1/0", bus.sys_rst_no, bus.rst_cause_o);
    end
    tests_run++;
    if (bus.fsm_state !== S_IDLE || bus.strikes_o !== 4'd0 || bus.irq_o !== 1'b0) begin
      fails++; $display("FAIL async_reset_state: got state=%0d strikes=%0d irq=%b want 0/0/0", bus.fsm_state, bus.strikes_o, bus.irq_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (bus.sys_rst_no !== 1'b1 || bus.fsm_state !== S_IDLE) begin
      fails++; $display("FAIL after_async_reset: got sys=%b state=%0d want 1/0", bus.sys_rst_no, bus.fsm_state);
    end
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    test_reset();
    test_event_warn();
    test_ack();
    test_ack_and_event();
    rise_wdov();
    tick();
    test_ack_and_event();
    test_escalate();
    test_en_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
